// File: rtl/piccolo80_key_sched.sv
// Piccolo-80 sequential key schedule: whitening keys per load, one round-key
// pair per round streamed to the iterative core on advance.
module piccolo80_key_sched #(
    parameter int unsigned NROUNDS = 25,
    parameter logic [31:0] CON_XOR = 32'h0F1E2D3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_load,
    input  logic [79:0] key_in,
    input  logic        advance,
    output logic [63:0] wk,
    output logic [31:0] rk,
    output logic [4:0]  round_idx,
    output logic        rk_valid,
    output logic        last,
    output logic        done
);

    localparam int unsigned KW = 80;
    localparam int unsigned RW = 32;
    localparam int unsigned IW = 5;
    localparam int unsigned MW = 3;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [KW-1:0]   key_q;
    logic [MW-1:0]   mod5;
    logic [IW-1:0]   idx_nxt;
    logic [MW-1:0]   m_nxt;

    // Round key for round idx; m is idx mod 5, tracked incrementally by the caller.
    function automatic logic [RW-1:0] round_key(input logic [KW-1:0] k,
                                                input logic [IW-1:0] idx,
                                                input logic [MW-1:0] m);
        logic [4:0]    c;
        logic [RW-1:0] con;
        logic [RW-1:0] sel;
        c   = idx + 5'd1;
        con = {c, 5'b0, c, 2'b00, c, 5'b0, c} ^ CON_XOR;
        case (m)
            3'd0, 3'd2: sel = k[47:16];              // {k2,k3}
            3'd1, 3'd4: sel = k[79:48];              // {k0,k1}
            default:    sel = {k[15:0], k[15:0]};    // {k4,k4}
        endcase
        return con ^ sel;
    endfunction

    // Next round index and wrapping mod-5 counter, no divider involved.
    always_comb begin
        idx_nxt = round_idx + IW'(1);
        m_nxt   = (mod5 == MW'(4)) ? '0 : mod5 + MW'(1);
    end

    // Schedule FSM: key capture, per-round advance, end-of-schedule done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            key_q     <= '0;
            mod5      <= '0;
            wk        <= '0;
            rk        <= '0;
            round_idx <= '0;
            rk_valid  <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (key_load) begin
                state     <= RUN;
                key_q     <= key_in;
                wk        <= {key_in[79:72], key_in[55:48],
                              key_in[63:56], key_in[71:64],
                              key_in[15:8],  key_in[23:16],
                              key_in[31:24], key_in[7:0]};
                rk        <= round_key(key_in, '0, '0);
                round_idx <= '0;
                mod5      <= '0;
                rk_valid  <= 1'b1;
                last      <= (NROUNDS == 1);
            end else if (state == RUN && advance) begin
                if (last) begin
                    state    <= IDLE;
                    rk_valid <= 1'b0;
                    last     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    round_idx <= idx_nxt;
                    mod5      <= m_nxt;
                    rk        <= round_key(key_q, idx_nxt, m_nxt);
                    last      <= (idx_nxt == IW'(NROUNDS - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_piccolo80_key_sched.sv
// Self-checking bench for piccolo80_key_sched against an arithmetic reference model.
module tb_piccolo80_key_sched;

    localparam int NR = 25;
    localparam logic [79:0] KEY_A = 80'h00112233445566778899;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_load;
    logic [79:0] key_in;
    logic        advance;
    logic [63:0] wk;
    logic [31:0] rk;
    logic [4:0]  round_idx;
    logic        rk_valid;
    logic        last;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    piccolo80_key_sched dut (
        .clk       (clk),
        .reset     (reset),
        .key_load  (key_load),
        .key_in    (key_in),
        .advance   (advance),
        .wk        (wk),
        .rk        (rk),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .last      (last),
        .done      (done)
    );

    // 16-bit key word n, k0 being the most significant.
    function automatic logic [15:0] kw(input logic [79:0] k, input int n);
        return k[79-16*n -: 16];
    endfunction

    function automatic logic [63:0] model_wk(input logic [79:0] k);
        logic [15:0] k0, k1, k3, k4;
        k0 = kw(k, 0); k1 = kw(k, 1); k3 = kw(k, 3); k4 = kw(k, 4);
        return {k0[15:8], k1[7:0], k1[15:8], k0[7:0],
                k4[15:8], k3[7:0], k3[15:8], k4[7:0]};
    endfunction

    function automatic logic [31:0] model_rk(input logic [79:0] k, input int i);
        logic [31:0] c, con;
        c   = 32'(i + 1);
        con = ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h0F1E2D3C;
        case (i % 5)
            0, 2:    return con ^ {kw(k, 2), kw(k, 3)};
            1, 4:    return con ^ {kw(k, 0), kw(k, 1)};
            default: return con ^ {kw(k, 4), kw(k, 4)};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_load = 1'b1; key_in = KEY_A; advance = 1'b1;
        tick(); tick();
        reset = 1'b0; key_load = 1'b0; advance = 1'b0;
        tick();
        tests_run++;
        if ({wk, rk, round_idx, rk_valid, last, done} !== 104'd0) begin
            tests_failed++;
            $display("FAIL reset_state: wk=%h rk=%h idx=%0d v=%b l=%b d=%b, required all 0",
                     wk, rk, round_idx, rk_valid, last, done);
        end
    endtask

    task automatic test_advance_without_load();
        advance = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if ({wk, rk, round_idx, rk_valid, last, done} !== 104'd0) begin
                tests_failed++;
                $display("FAIL adv_no_load: cyc=%0d rk=%h idx=%0d v=%b d=%b, required all 0",
                         c, rk, round_idx, rk_valid, done);
            end
        end
        advance = 1'b0;
    endtask

    task automatic test_known_vectors();
        key_in = KEY_A; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tests_run++;
        if (wk !== 64'h0033_2211_8877_6699 || rk !== 32'h43494F4A ||
            round_idx !== 5'd0 || rk_valid !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL vec_round0: wk=%h rk=%h idx=%0d v=%b, required wk=0033221188776699 rk=43494f4a idx=0 v=1",
                     wk, rk, round_idx, rk_valid);
        end
        advance = 1'b1; tick(); advance = 1'b0;
        tests_run++;
        if (rk !== 32'h1F0B070D || round_idx !== 5'd1) begin
            tests_failed++;
            $display("FAIL vec_round1: rk=%h idx=%0d, required rk=1f0b070d idx=1", rk, round_idx);
        end
        advance = 1'b1; tick(); tick(); advance = 1'b0;
        tests_run++;
        if (rk !== 32'hA78FB5A1 || round_idx !== 5'd3) begin
            tests_failed++;
            $display("FAIL vec_round3: rk=%h idx=%0d, required rk=a78fb5a1 idx=3", rk, round_idx);
        end
    endtask

    task automatic test_full_schedule(input logic [79:0] key);
        int idx;
        key_in = key; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        idx = 0;
        while (1) begin
            tests_run++;
            if (rk_valid !== 1'b1 || done !== 1'b0 || round_idx !== 5'(idx) ||
                last !== (idx == NR - 1) || rk !== model_rk(key, idx) || wk !== model_wk(key)) begin
                tests_failed++;
                $display("FAIL sched_round: idx=%0d got rk=%h idx=%0d v=%b l=%b d=%b, required rk=%h l=%b",
                         idx, rk, round_idx, rk_valid, last, done, model_rk(key, idx), idx == NR - 1);
            end
            if (idx == NR - 1) break;
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            tests_run++;
            if (round_idx !== 5'(idx) || rk !== model_rk(key, idx)) begin
                tests_failed++;
                $display("FAIL sched_hold: idx=%0d got rk=%h idx=%0d, required rk=%h",
                         idx, rk, round_idx, model_rk(key, idx));
            end
            advance = 1'b1; tick(); advance = 1'b0;
            idx++;
        end
        advance = 1'b1; tick(); advance = 1'b0;
        tests_run++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || last !== 1'b0 ||
            round_idx !== 5'(NR - 1) || wk !== model_wk(key)) begin
            tests_failed++;
            $display("FAIL sched_done: d=%b v=%b l=%b idx=%0d wk=%h, required d=1 v=0 l=0 idx=24 wk=%h",
                     done, rk_valid, last, round_idx, wk, model_wk(key));
        end
        for (int c = 0; c < 3; c++) begin
            advance = c[0];
            tick();
            tests_run++;
            if (done !== 1'b0 || rk_valid !== 1'b0 || round_idx !== 5'(NR - 1) || wk !== model_wk(key)) begin
                tests_failed++;
                $display("FAIL sched_after: cyc=%0d d=%b v=%b idx=%0d, required d=0 v=0 idx=24",
                         c, done, rk_valid, round_idx);
            end
        end
        advance = 1'b0;
    endtask

    task automatic test_back_to_back(input logic [79:0] key);
        key_in = key; key_load = 1'b1;
        tick();
        key_load = 1'b0; advance = 1'b1;
        for (int k = 1; k <= NR + 2; k++) begin
            tick();
            tests_run++;
            if (k < NR) begin
                if (rk_valid !== 1'b1 || round_idx !== 5'(k) || rk !== model_rk(key, k) ||
                    last !== (k == NR - 1) || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_round: k=%0d got rk=%h idx=%0d v=%b l=%b, required rk=%h",
                             k, rk, round_idx, rk_valid, last, model_rk(key, k));
                end
            end else if (done !== (k == NR) || rk_valid !== 1'b0 || round_idx !== 5'(NR - 1)) begin
                tests_failed++;
                $display("FAIL b2b_end: k=%0d d=%b v=%b idx=%0d, required d=%b v=0 idx=24",
                         k, done, rk_valid, round_idx, k == NR);
            end
        end
        advance = 1'b0;
    endtask

    task automatic test_load_advance_collision(input int at_round);
        key_in = {$urandom, $urandom, 16'($urandom)}; key_load = 1'b1;
        tick();
        key_load = 1'b0; advance = 1'b1;
        for (int k = 0; k < at_round; k++) tick();
        key_in = KEY_A; key_load = 1'b1;
        tick();
        key_load = 1'b0; advance = 1'b0;
        tests_run++;
        if (round_idx !== 5'd0 || rk !== 32'h43494F4A || rk_valid !== 1'b1 ||
            done !== 1'b0 || last !== 1'b0 || wk !== model_wk(KEY_A)) begin
            tests_failed++;
            $display("FAIL collide_r%0d: idx=%0d rk=%h v=%b d=%b l=%b, required idx=0 rk=43494f4a v=1 d=0 l=0",
                     at_round, round_idx, rk, rk_valid, done, last);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || round_idx !== 5'd0) begin
            tests_failed++;
            $display("FAIL collide_nodone_r%0d: d=%b idx=%0d, required d=0 idx=0", at_round, done, round_idx);
        end
    endtask

    task automatic test_reset_priority();
        key_in = KEY_A; key_load = 1'b1;
        tick();
        key_load = 1'b0; advance = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        advance = 1'b0;
        tests_run++;
        if (round_idx !== 5'd7 || rk !== model_rk(KEY_A, 7)) begin
            tests_failed++;
            $display("FAIL rst_setup: idx=%0d rk=%h, required idx=7 rk=%h", round_idx, rk, model_rk(KEY_A, 7));
        end
        reset = 1'b1; key_load = 1'b1;
        tick();
        reset = 1'b0; key_load = 1'b0;
        tests_run++;
        if ({wk, rk, round_idx, rk_valid, last, done} !== 104'd0) begin
            tests_failed++;
            $display("FAIL rst_priority: wk=%h rk=%h idx=%0d v=%b, required all 0", wk, rk, round_idx, rk_valid);
        end
        advance = 1'b1; tick(); tick(); advance = 1'b0;
        tests_run++;
        if ({wk, rk, round_idx, rk_valid, last, done} !== 104'd0) begin
            tests_failed++;
            $display("FAIL rst_idle: rk=%h idx=%0d v=%b d=%b, required all 0", rk, round_idx, rk_valid, done);
        end
    endtask

    initial begin
        reset = 1'b1; key_load = 1'b0; key_in = '0; advance = 1'b0;
        test_reset();
        test_advance_without_load();
        test_known_vectors();
        test_full_schedule(KEY_A);
        for (int t = 0; t < 3; t++) test_full_schedule({$urandom, $urandom, 16'($urandom)});
        test_back_to_back({$urandom, $urandom, 16'($urandom)});
        test_load_advance_collision(10);
        test_load_advance_collision(NR - 1);
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/piccolo80_key_sched.md
Name: piccolo80_key_sched

Overview:
- Sequential Piccolo-80 key schedule that sits directly upstream of the iterative round datapath.
- Captures an 80-bit master key and emits the four 16-bit whitening keys once per key load.
- Streams one 32-bit round-key pair (rk2i‖rk2i+1) per round for rounds 0..24, advanced by the consuming core.
- Replaces the core's hard-wired key constant; round constants are produced by an incremental counter, with no per-round combinational divide or modulo.

Parameters:
- NROUNDS, 25, number of rounds streamed; index range 0..NROUNDS-1.
- CON_XOR, 32'h0F1E2D3C, constant XORed into every generated round-constant word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- key_load  input  1  one-cycle strobe; capture key_in and restart the schedule.
- key_in  input  80  master key, bit 0 = MSB; k0=key_in[0:15] .. k4=key_in[64:79].
- advance  input  1  core consumed the current rk; step to the next round.
- wk  output  64  {wk0,wk1,wk2,wk3}, registered.
- rk  output  32  {rk2i,rk2i+1} for the current round, registered.
- round_idx  output  5  current round i.
- rk_valid  output  1  rk/round_idx/wk are valid.
- last  output  1  high while round_idx == NROUNDS-1 and rk_valid.
- done  output  1  one-cycle pulse after the last round is consumed.

Behaviour:
- Reset state:
  - All outputs and internal registers = 0.
  - FSM state = IDLE.
- FSM states: IDLE, RUN.
- Transitions:
  - IDLE -> RUN on key_load.
  - RUN -> IDLE on advance while last is high; done=1 for exactly that following cycle.
  - RUN -> RUN on key_load (restart).
- key_load (any state), with the registers below taking these values the cycle after the strobe:
  - Key register <- key_in.
  - round_idx <- 0; mod5 counter <- 0; rk_valid <- 1.
  - rk <- the round-0 value computed from key_in directly, so there is no bubble.
- Whitening keys, registered on key_load and held until the next load:
  - wk0 = k0[0:7]‖k1[8:15]
  - wk1 = k1[0:7]‖k0[8:15]
  - wk2 = k4[0:7]‖k3[8:15]
  - wk3 = k3[0:7]‖k4[8:15]
- Round constant for round i:
  - c = 5-bit (i+1).
  - con = {c, 5'b0, c, 2'b00, c, 5'b0, c} ^ CON_XOR.
- Round key, selected by the mod5 counter m:
  - rk = con ^ {k2,k3} when m ∈ {0,2}.
  - rk = con ^ {k0,k1} when m ∈ {1,4}.
  - rk = con ^ {k4,k4} when m == 3.
  - m wraps 4 -> 0 and is maintained alongside round_idx.
- Advancing (advance && rk_valid && !last):
  - round_idx += 1, m steps, and rk is updated to the next round's value on the same edge.
  - Latency advance -> new rk: 1 cycle.
- Ignored events:
  - advance when rk_valid=0 is ignored.
  - advance held high advances once per cycle.
- Simultaneous key_load and advance: key_load wins and the schedule restarts at round 0; no done pulse.
- reset during RUN: immediate return to reset state on the next edge; takes priority over key_load.
- Wrap-around: after round NROUNDS-1 is consumed, round_idx stays at NROUNDS-1, rk_valid drops to 0, and wk holds its value.

Test Plan:
- Reset, then key_load with key_in=80'h00112233445566778899 -> next cycle:
  - wk=64'h0033_2211_8877_6699
  - rk=32'h43494F4A
  - round_idx=0, rk_valid=1
- Same key, one advance -> next cycle rk=32'h1F0B070D, round_idx=1. Continue to round 3 -> rk low and high halves are both XORed with 8899, i.e. rk = con ^ {8899,8899}.
- 24 advances with random gaps -> last high exactly at round 24. 25th advance -> done pulses for one cycle, rk_valid=0. Further advances -> no change.
- key_load and advance asserted together at round 10 -> round_idx=0, rk=32'h43494F4A, no done.
- reset asserted at round 7 together with key_load -> all outputs 0, FSM in IDLE.
- advance with no prior key_load after reset -> outputs remain 0, no done.
